// File: rtl/sopc_bus_pkg.sv
// Shared types and default address map for the SOPC data-bus controller.
package sopc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_NUM_SLAVES = 4;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_TIMEOUT    = 16;

  // Slave 0 in the LSBs; each slave owns one 256 MB window.
  localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_SLAVE_BASE = {
    32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
  };

  localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_SLAVE_MASK = {
    DEF_NUM_SLAVES{32'hF000_0000}
  };

endpackage

// File: rtl/sopc_bus_ctrl_if.sv
// CPU-side and slave-side bus signals of the controller.
// master: the controller's view (serves the CPU, drives the slave bus).
// slave:  the environment's view (CPU plus slaves).
interface sopc_bus_ctrl_if #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32
);

  logic                         m_ce_i;
  logic                         m_we_i;
  logic [ADDR_W-1:0]            m_addr_i;
  logic [DATA_W/8-1:0]          m_sel_i;
  logic [DATA_W-1:0]            m_data_i;
  logic [DATA_W-1:0]            m_data_o;
  logic                         m_stall_o;
  logic                         m_err_o;

  logic [NUM_SLAVES-1:0]        s_ce_o;
  logic                         s_we_o;
  logic [ADDR_W-1:0]            s_addr_o;
  logic [DATA_W/8-1:0]          s_sel_o;
  logic [DATA_W-1:0]            s_data_o;
  logic [NUM_SLAVES*DATA_W-1:0] s_data_i;
  logic [NUM_SLAVES-1:0]        s_ack_i;

  modport master (
    input  m_ce_i, m_we_i, m_addr_i, m_sel_i, m_data_i,
    output m_data_o, m_stall_o, m_err_o,
    output s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o,
    input  s_data_i, s_ack_i
  );

  modport slave (
    output m_ce_i, m_we_i, m_addr_i, m_sel_i, m_data_i,
    input  m_data_o, m_stall_o, m_err_o,
    input  s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o,
    output s_data_i, s_ack_i
  );

endinterface

// File: rtl/sopc_addr_decoder.sv
// Combinational base/mask address decode; lowest matching slave index wins.
module sopc_addr_decoder
  import sopc_bus_pkg::*;
#(
  parameter int                             NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int                             ADDR_W     = DEF_ADDR_W,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLAVE_BASE = (NUM_SLAVES*ADDR_W)'(DEF_SLAVE_BASE),
  parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLAVE_MASK = (NUM_SLAVES*ADDR_W)'(DEF_SLAVE_MASK)
) (
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [NUM_SLAVES-1:0] o_sel_oh,
  output logic                  o_hit
);

  // Walk from the highest index down so the lowest match overwrites the rest.
  always_comb begin
    o_sel_oh = '0;
    o_hit    = 1'b0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((i_addr & SLAVE_MASK[k*ADDR_W +: ADDR_W]) == SLAVE_BASE[k*ADDR_W +: ADDR_W]) begin
        o_sel_oh    = '0;
        o_sel_oh[k] = 1'b1;
        o_hit       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sopc_bus_ctrl.sv
// CPU data-bus controller: decodes the request, drives one slave until it
// acks or the timeout expires, then reports data/error for one cycle.
//
// state | meaning
// IDLE  | no transfer; a request with a decode hit latches and goes BUSY
// BUSY  | selected slave enabled, waiting for its ack or the timeout
// DONE  | one cycle, stall released, m_err_o valid
module sopc_bus_ctrl
  import sopc_bus_pkg::*;
#(
  parameter int                           NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int                           DATA_W     = DEF_DATA_W,
  parameter int                           ADDR_W     = DEF_ADDR_W,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = (NUM_SLAVES*ADDR_W)'(DEF_SLAVE_BASE),
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = (NUM_SLAVES*ADDR_W)'(DEF_SLAVE_MASK),
  parameter int                           TIMEOUT    = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               rst,
  sopc_bus_ctrl_if.master   bus
);

  localparam int         CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_BUSY = ST_BUSY;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_err;
  logic [DATA_W-1:0]     r_m_data;
  logic [NUM_SLAVES-1:0] r_slv_oh;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W/8-1:0]   r_sel;
  logic [DATA_W-1:0]     r_wdata;

  logic [NUM_SLAVES-1:0] w_dec_oh;
  logic                  w_dec_hit;
  logic                  w_ack;
  logic [DATA_W-1:0]     w_rdata;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_tmo;

  sopc_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_dec (
    .i_addr   (bus.m_addr_i),
    .o_sel_oh (w_dec_oh),
    .o_hit    (w_dec_hit)
  );

  // Only the latched slave's ack and read data are visible; others are masked.
  always_comb begin
    w_ack   = |(bus.s_ack_i & r_slv_oh);
    w_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (r_slv_oh[k]) begin
        w_rdata = w_rdata | bus.s_data_i[k*DATA_W +: DATA_W];
      end
    end
    // The current BUSY cycle is number r_cnt+1; expiring on TIMEOUT gives exactly TIMEOUT BUSY cycles.
    w_cnt_inc = r_cnt + 1'b1;
    w_tmo     = (w_cnt_inc == CNT_W'(TIMEOUT));
  end

  // Transfer sequencing, request latching and result capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_m_data <= '0;
      r_slv_oh <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_sel    <= '0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.m_ce_i) begin
            if (w_dec_hit) begin
              r_we     <= bus.m_we_i;
              r_addr   <= bus.m_addr_i;
              r_sel    <= bus.m_sel_i;
              r_wdata  <= bus.m_data_i;
              r_slv_oh <= w_dec_oh;
              r_cnt    <= '0;
              r_err    <= 1'b0;
              r_state  <= S_BUSY;
            end else begin
              r_err    <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          if (w_ack) begin
            if (!r_we) begin
              r_m_data <= w_rdata;
            end
            r_err   <= 1'b0;
            r_state <= S_DONE;
          end else if (w_tmo) begin
            r_m_data <= '0;
            r_err    <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stall is combinational so the CPU holds its request in the request cycle itself.
  always_comb begin
    bus.m_stall_o = rst & (((r_state == S_IDLE) & bus.m_ce_i) | (r_state == S_BUSY));
    bus.m_err_o   = (r_state == S_DONE) & r_err;
    bus.s_ce_o    = (r_state == S_BUSY) ? r_slv_oh : '0;
  end

  assign bus.m_data_o = r_m_data;
  assign bus.s_we_o   = r_we;
  assign bus.s_addr_o = r_addr;
  assign bus.s_sel_o  = r_sel;
  assign bus.s_data_o = r_wdata;

endmodule
